nibble_bus_arbiter: RTL

- Shares the external nibble bus between two requesters and sequences every bus transaction.
- The bus is a 7-bit address latch, a 4-bit SRAM and 2-bit external devices multiplexed on one 8-bit output.
- Port 0 is the CPU core; port 1 is a loader/debug engine that fills code space before or while the CPU runs.
- The block owns the strobe/address/data timing, so requesters only issue address + data + direction.

---
 rtl/nibble_bus_arbiter_if.sv | 31 +++
 rtl/nibble_bus_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/nibble_bus_arbiter_if.sv
// Request/response and external-bus signals of the nibble bus arbiter.
// master = requester/board side, slave = arbiter side.
interface nibble_bus_arbiter_if #(
    parameter int ADDR_W = 7
);
    logic              req0, req1;
    logic              we0, we1;
    logic              dev0, dev1;
    logic              space0, space1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [3:0]        wdata0, wdata1;
    logic              done0, done1;
    logic [3:0]        rdata;
    logic              gnt;
    logic              busy;
    logic [3:0]        ram_in;
    logic [1:0]        dev_in;
    logic [7:0]        bus_out;

    modport master (
        output req0, req1, we0, we1, dev0, dev1, space0, space1,
               addr0, addr1, wdata0, wdata1, ram_in, dev_in,
        input  done0, done1, rdata, gnt, busy, bus_out
    );

    modport slave (
        input  req0, req1, we0, we1, dev0, dev1, space0, space1,
               addr0, addr1, wdata0, wdata1, ram_in, dev_in,
        output done0, done1, rdata, gnt, busy, bus_out
    );
endinterface

// File: rtl/nibble_bus_arbiter.sv
// Two-port arbiter and transaction sequencer for the multiplexed nibble bus.
// NIBBLE_BUS_RR_EN selects round-robin arbitration; default is fixed priority (port 1 wins).
module nibble_bus_arbiter #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 7
) (
    input logic                clk,
    input logic                reset_n,
    nibble_bus_arbiter_if.slave bus
);
    localparam int        NUM_PORTS = 2;
    localparam logic [7:0] IDLE_BUS = 8'h30;
    localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef struct packed {
        logic       we;
        logic       dev;
        logic       space;
        logic [3:0] wdata;
    } ctl_t;

    typedef struct packed {
        ctl_t              ctl;
        logic [ADDR_W-1:0] addr;
    } req_t;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

    state_t                  state;
    ctl_t                    cap;
    logic [2:0]              wait_cnt;
    logic [NUM_PORTS-1:0]    done_q;
    logic [3:0]              rdata_q;
    logic                    gnt_q;
    logic                    busy_q;
    logic [7:0]              bus_q;

    req_t [NUM_PORTS-1:0]    port_req;
    logic [NUM_PORTS-1:0]    req_v;
    logic [NUM_PORTS-1:0]    elig;
    logic                    grant_any;
    logic                    win;

    assign port_req[0] = '{ctl: '{we: bus.we0, dev: bus.dev0, space: bus.space0, wdata: bus.wdata0},
                           addr: bus.addr0};
    assign port_req[1] = '{ctl: '{we: bus.we1, dev: bus.dev1, space: bus.space1, wdata: bus.wdata1},
                           addr: bus.addr1};
    assign req_v = {bus.req1, bus.req0};
    // A port still pulsing done is finishing its previous transaction, not asking for a new one.
    assign elig  = req_v & ~done_q;

    function automatic logic [7:0] data_bus(input ctl_t c);
        return {1'b0, c.space, ~(c.we & ~c.dev), ~(c.we & c.dev), c.wdata};
    endfunction

`ifdef NIBBLE_BUS_RR_EN
    logic rr_ptr;

    always_comb begin
        grant_any = |elig;
        win       = elig[1];
        if (&elig) win = rr_ptr;
    end
`else
    // Port 0 only gets the bus when the loader is not requesting at all, so a loader
    // holding req across its done keeps the bus on the following cycle.
    always_comb begin
        grant_any = elig[1] | (elig[0] & ~bus.req1);
        win       = elig[1];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cap      <= '0;
            wait_cnt <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            gnt_q    <= 1'b0;
            busy_q   <= 1'b0;
            bus_q    <= IDLE_BUS;
`ifdef NIBBLE_BUS_RR_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state  <= ADDR;
                        gnt_q  <= win;
                        cap    <= port_req[win].ctl;
                        busy_q <= 1'b1;
                        bus_q  <= {1'b1, port_req[win].addr};
`ifdef NIBBLE_BUS_RR_EN
                        rr_ptr <= ~win;
`endif
                    end else begin
                        bus_q <= IDLE_BUS;
                    end
                end
                ADDR: begin
                    bus_q    <= data_bus(cap);
                    wait_cnt <= WAIT_INIT;
                    state    <= (WAIT_CYCLES == 0) ? DATA : WAIT;
                end
                WAIT: begin
                    bus_q <= data_bus(cap);
                    if (wait_cnt == 3'd0) state <= DATA;
                    else                  wait_cnt <= wait_cnt - 3'd1;
                end
                DATA: begin
                    state         <= IDLE;
                    busy_q        <= 1'b0;
                    done_q[gnt_q] <= 1'b1;
                    bus_q         <= IDLE_BUS;
                    if (!cap.we) rdata_q <= cap.dev ? {2'b00, bus.dev_in} : bus.ram_in;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.done0   = done_q[0];
    assign bus.done1   = done_q[1];
    assign bus.rdata   = rdata_q;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.bus_out = bus_q;
endmodule
